ode_step_sequencer: RTL and testbench



---
 rtl/ode_step_sequencer_if.sv | 41 ++++
 rtl/ode_step_sequencer.sv | 152 +++++++++++++++
 tb/tb_ode_step_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ode_step_sequencer_if.sv
// Handshake bundle between the control/stage side and the ODE step sequencer.
interface ode_step_sequencer_if #(
  parameter int unsigned W          = 32,
  parameter int unsigned N          = 6,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned STEP_CNT_W = 16
);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                  enable;
  logic                  abort;
  logic [STEP_CNT_W-1:0] num_steps;
  logic [N*W-1:0]        initial_value;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  wb_valid;
  logic [IDX_W-1:0]      wb_index;
  logic [W-1:0]          wb_data;
  logic [N*W-1:0]        state_vec;
  logic [STEP_CNT_W-1:0] step_count;
  logic                  busy;
  logic                  data_ready;
  logic                  run_done;
  logic                  error;

  // Control / stage-unit side
  modport master (
    output enable, abort, num_steps, initial_value, stage_done,
           wb_valid, wb_index, wb_data,
    input  stage_start, state_vec, step_count, busy, data_ready,
           run_done, error
  );

  // Sequencer side
  modport slave (
    input  enable, abort, num_steps, initial_value, stage_done,
           wb_valid, wb_index, wb_data,
    output stage_start, state_vec, step_count, busy, data_ready,
           run_done, error
  );
endinterface

// File: rtl/ode_step_sequencer.sv
// ODE step sequencer: holds the state vector and, for each of num_steps time
// steps, launches NUM_STAGES compute stages in order over start/done
// handshakes, with a per-stage watchdog, abort and state write-back.
module ode_step_sequencer #(
  parameter int unsigned EXP_LEN        = 8,
  parameter int unsigned MANTISSA_LEN   = 23,
  parameter int unsigned NUM_STATE_VAR  = 3,
  parameter int unsigned DIFF_EQN_ORDER = 2,
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned STEP_CNT_W     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset,
  ode_step_sequencer_if.slave bus
);
  localparam int unsigned W      = EXP_LEN + MANTISSA_LEN + 1;
  localparam int unsigned N      = NUM_STATE_VAR * DIFF_EQN_ORDER;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SIDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [SIDX_W-1:0]     stage_q, stage_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [STEP_CNT_W-1:0] steps_q, steps_d;
  logic [STEP_CNT_W-1:0] count_q, count_d;
  logic [N*W-1:0]        vec_q, vec_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  run_done_q, run_done_d;
  logic                  error_q, error_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    wd_d       = wd_q;
    steps_d    = steps_q;
    count_d    = count_q;
    vec_d      = vec_q;
    start_d    = '0;
    busy_d     = busy_q;
    ready_d    = ready_q;
    run_done_d = 1'b0;
    error_d    = error_q;

    // Out-of-range indices simply match no word and are dropped.
    if (busy_q && bus.wb_valid) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.wb_index == IDX_W'(i)) vec_d[i*W +: W] = bus.wb_data;
      end
    end

    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            vec_d   = bus.initial_value;
            steps_d = bus.num_steps;
            count_d = '0;
            error_d = 1'b0;
            wd_d    = '0;
            stage_d = '0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            state_d = (bus.num_steps == '0) ? S_FINISH : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          start_d[stage_q] = 1'b1;
          wd_d             = '0;
          state_d          = S_WAIT;
        end
        S_WAIT: begin
          if (bus.stage_done[stage_q]) begin
            if (stage_q == SIDX_W'(NUM_STAGES - 1)) begin
              count_d = STEP_CNT_W'(count_q + 1'b1);
              stage_d = '0;
              state_d = (count_d == steps_q) ? S_FINISH : S_LAUNCH;
            end else begin
              stage_d = stage_q + 1'b1;
              state_d = S_LAUNCH;
            end
          end else begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 2)) state_d = S_ERROR;
          end
        end
        S_FINISH: begin
          run_done_d = 1'b1;
          busy_d     = 1'b0;
          ready_d    = 1'b1;
          state_d    = S_IDLE;
        end
        S_ERROR: begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      wd_q       <= '0;
      steps_q    <= '0;
      count_q    <= '0;
      vec_q      <= '0;
      start_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      run_done_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      wd_q       <= wd_d;
      steps_q    <= steps_d;
      count_q    <= count_d;
      vec_q      <= vec_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      run_done_q <= run_done_d;
      error_q    <= error_d;
    end
  end

  assign bus.stage_start = start_q;
  assign bus.state_vec   = vec_q;
  assign bus.step_count  = count_q;
  assign bus.busy        = busy_q;
  assign bus.data_ready  = ready_q;
  assign bus.run_done    = run_done_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_ode_step_sequencer.sv
// Directed bench for ode_step_sequencer: stage-start order is scoreboarded,
// stage units are modelled by an auto responder or by manual done pulses.
module tb_ode_step_sequencer;
  localparam int unsigned W = 32;
  localparam int unsigned N = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ode_step_sequencer_if #(.W(W), .N(N), .NUM_STAGES(3), .STEP_CNT_W(16)) bus ();

  ode_step_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [2:0] resp_done;
  logic [2:0] man_done;
  assign bus.stage_done = resp_done | man_done;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int n_starts = 0;
  int exp_q[$];
  bit auto_en;
  int skip;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each observed stage_start must match the next expected stage
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.run_done) rd_cnt++;
      if (bus.stage_start != '0) begin
        n_starts++;
        if (exp_q.size() == 0) check("unexpected_start", 256'(bus.stage_start), '0);
        else begin
          logic [2:0] oh;
          int e;
          e  = exp_q.pop_front();
          oh = 3'b001 << e;
          check("start_order", 256'(bus.stage_start), 256'(oh));
        end
      end
    end
  end

  // Auto responder: done returned 3 cycles after each start (except stage skip)
  initial begin
    bit pend = 0;
    int pk = 0;
    int cnt = 0;
    resp_done = '0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          resp_done[pk] = 1'b1;
          pend = 0;
        end
      end
      if (auto_en && bus.stage_start != '0) begin
        for (int k = 0; k < 3; k++) begin
          if (bus.stage_start[k] && k != skip) begin
            pend = 1; pk = k; cnt = 3;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic start_run(input logic [15:0] steps, input logic [N*W-1:0] iv);
    @(negedge clk);
    bus.num_steps     = steps;
    bus.initial_value = iv;
    bus.enable        = 1'b1;
    @(negedge clk);
    bus.enable        = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.data_ready && !bus.busy) begin ok = 1; break; end
    end
    check(tag, 256'(ok), 256'(1));
    @(negedge clk);
  endtask

  task automatic wait_start(input int k, input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stage_start[k]) begin ok = 1; break; end
    end
    check(tag, 256'(ok), 256'(1));
  endtask

  task automatic pulse_done(input int k);
    man_done[k] = 1'b1;
    @(negedge clk);
    man_done = '0;
  endtask

  initial begin
    logic [N*W-1:0] iv1, iv2, exp1;
    int s0;
    reset = 1'b1;
    bus.enable = 1'b0; bus.abort = 1'b0; bus.num_steps = '0;
    bus.initial_value = '0; bus.wb_valid = 1'b0; bus.wb_index = '0; bus.wb_data = '0;
    man_done = '0; auto_en = 1; skip = -1;
    for (int i = 0; i < N; i++) begin
      iv1[i*W +: W] = 32'h4000_0000 + 32'(i);
      iv2[i*W +: W] = 32'hC100_0000 + 32'(i * 3);
    end
    exp1 = iv1;
    exp1[4*W +: W] = 32'h3F80_0000;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_ready", 256'(bus.data_ready), 256'(1));
    check("rst_count", 256'(bus.step_count), 256'(0));
    check("rst_vec", 256'(bus.state_vec), 256'(0));
    check("rst_start", 256'(bus.stage_start), 256'(0));
    check("rst_rundone", 256'(bus.run_done), 256'(0));
    check("rst_error", 256'(bus.error), 256'(0));
    reset = 1'b0;

    // Normal two-step run with write-back; write in enable cycle is dropped
    for (int r = 0; r < 2; r++) for (int s = 0; s < 3; s++) exp_q.push_back(s);
    @(negedge clk);
    bus.num_steps = 16'd2; bus.initial_value = iv1; bus.enable = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_index = 3'd0; bus.wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.enable = 1'b0; bus.wb_index = 3'd7; bus.wb_data = 32'h0000_BEEF;
    check("run1_vec_latch", 256'(bus.state_vec), 256'(iv1));
    check("run1_busy", 256'(bus.busy), 256'(1));
    check("run1_ready", 256'(bus.data_ready), 256'(0));
    @(negedge clk);
    bus.wb_index = 3'd4; bus.wb_data = 32'h3F80_0000;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    wait_idle("run1_idle");
    check("run1_rundone_cnt", 256'(rd_cnt), 256'(1));
    check("run1_count", 256'(bus.step_count), 256'(2));
    check("run1_vec_wb", 256'(bus.state_vec), 256'(exp1));
    check("run1_sb_empty", 256'(exp_q.size()), 256'(0));

    // Writes in IDLE are dropped
    bus.wb_valid = 1'b1; bus.wb_index = 3'd7; bus.wb_data = 32'h1111_1111;
    @(negedge clk);
    bus.wb_index = 3'd1;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    @(negedge clk);
    check("idle_wb_dropped", 256'(bus.state_vec), 256'(exp1));

    // Watchdog: stage 1 never answers
    skip = 1;
    exp_q.push_back(0); exp_q.push_back(1);
    start_run(16'd3, iv1);
    wait_start(1, "wd_start1_seen");
    repeat (7) @(negedge clk);
    check("wd_error_early", 256'(bus.error), 256'(0));
    @(negedge clk);
    check("wd_error", 256'(bus.error), 256'(1));
    check("wd_ready", 256'(bus.data_ready), 256'(1));
    check("wd_busy", 256'(bus.busy), 256'(0));
    check("wd_count", 256'(bus.step_count), 256'(0));
    skip = -1;
    repeat (2) @(negedge clk);
    check("wd_error_sticky", 256'(bus.error), 256'(1));

    // num_steps=0: no starts, run_done two cycles later, error cleared
    s0 = n_starts;
    start_run(16'd0, iv2);
    check("zero_error_clr", 256'(bus.error), 256'(0));
    check("zero_vec", 256'(bus.state_vec), 256'(iv2));
    check("zero_busy", 256'(bus.busy), 256'(1));
    check("zero_rundone_early", 256'(bus.run_done), 256'(0));
    @(negedge clk);
    check("zero_rundone", 256'(bus.run_done), 256'(1));
    check("zero_ready", 256'(bus.data_ready), 256'(1));
    check("zero_count", 256'(bus.step_count), 256'(0));
    @(negedge clk);
    check("zero_rundone_cnt", 256'(rd_cnt), 256'(2));
    check("zero_no_start", 256'(n_starts), 256'(s0));

    // Abort coincident with stage_done[2] in step 1
    auto_en = 0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    start_run(16'd2, iv1);
    wait_start(0, "ab_start0");
    pulse_done(0);
    wait_start(1, "ab_start1");
    pulse_done(1);
    wait_start(2, "ab_start2");
    man_done = 3'b100; bus.abort = 1'b1;
    @(negedge clk);
    man_done = '0; bus.abort = 1'b0;
    check("ab_busy", 256'(bus.busy), 256'(0));
    check("ab_ready", 256'(bus.data_ready), 256'(1));
    check("ab_rundone", 256'(bus.run_done), 256'(0));
    check("ab_count", 256'(bus.step_count), 256'(0));
    check("ab_vec", 256'(bus.state_vec), 256'(iv1));
    s0 = n_starts;
    repeat (6) @(negedge clk);
    check("ab_no_more_start", 256'(n_starts), 256'(s0));
    check("ab_rundone_cnt", 256'(rd_cnt), 256'(2));
    check("ab_sb_empty", 256'(exp_q.size()), 256'(0));

    // Wrong done bit while waiting on stage 0 is ignored
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    start_run(16'd1, iv2);
    wait_start(0, "wd2_start0");
    man_done = 3'b100;
    @(negedge clk);
    man_done = '0;
    s0 = n_starts;
    repeat (3) @(negedge clk);
    check("wrongdone_no_start", 256'(n_starts), 256'(s0));
    check("wrongdone_busy", 256'(bus.busy), 256'(1));
    pulse_done(0);
    wait_start(1, "wd2_start1");
    pulse_done(1);
    wait_start(2, "wd2_start2");
    pulse_done(2);
    wait_idle("wd2_idle");
    check("wd2_count", 256'(bus.step_count), 256'(1));
    check("wd2_rundone_cnt", 256'(rd_cnt), 256'(3));
    check("wd2_error", 256'(bus.error), 256'(0));
    check("wd2_sb_empty", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
